// File: rtl/mtimer_pkg.sv
// Shared address map, helpers and types for the multi-channel machine timer.
package mtimer_pkg;

  typedef logic [63:0] time64_t;

  localparam int ADDR_MTIME_LO = 0;
  localparam int ADDR_MTIME_HI = 1;
  localparam int ADDR_STATUS   = 2;
  localparam int ADDR_ENABLE   = 3;
  localparam int ADDR_CMP_BASE = 4;

  function automatic int cmp_lo_addr(input int k);
    return ADDR_CMP_BASE + 2 * k;
  endfunction

  function automatic int cmp_hi_addr(input int k);
    return ADDR_CMP_BASE + 2 * k + 1;
  endfunction

endpackage

// File: rtl/mtimer_comparator.sv
// One mtimecmp channel: owns its two bus words and its registered interrupt line.
module mtimer_comparator
  import mtimer_pkg::*;
#(
  parameter int K      = 0,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  input  time64_t           mtime,
  input  logic              enable,
  output logic [31:0]       rdata,
  output logic              irq
);

  time64_t cmp_q, cmp_d;
  logic    irq_q;
  logic    sel_lo, sel_hi;

  assign sel_lo = (address == ADDR_W'(cmp_lo_addr(K)));
  assign sel_hi = (address == ADDR_W'(cmp_hi_addr(K)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cmp_d = cmp_q;
    if (write && sel_lo) cmp_d[31:0]  = wdata;
    if (write && sel_hi) cmp_d[63:32] = wdata;
  end

  // NOTE: state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmp_q <= '1;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      irq_q <= enable && (mtime >= cmp_q);
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel_lo)      rdata = cmp_q[31:0];
    else if (sel_hi) rdata = cmp_q[63:32];
  end

  assign irq = irq_q;

endmodule

// File: rtl/multi_channel_timer.sv
// Memory-mapped 64-bit machine timer with CHANNELS comparators on a 32-bit tristate bus.
// Define MTIMER_SNAPSHOT_EN to latch mtime[63:32] on a low-word read for coherent 64-bit reads.
module multi_channel_timer
  import mtimer_pkg::*;
#(
  parameter  int FREQUENCY = 100_000_000,
  parameter  int TICK_HZ   = 1_000_000,
  parameter  int CHANNELS  = 2,
  localparam int ADDR_W    = $clog2(4 + 2 * CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  inout  wire  [31:0]         data,
  output logic [CHANNELS-1:0] timer_interrupt
);

  localparam int DIVIDER = FREQUENCY / TICK_HZ;
  localparam int PW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  time64_t             mtime_q, mtime_d;
  logic [CHANNELS-1:0] enable_q, enable_d;
  logic                tick, wr_lo, wr_hi, rd_lo;
  logic [31:0]         hi_rd, cmp_or, rd_data;
  logic [31:0]         cmp_rdata [CHANNELS];

  assign tick  = (presc_q == PW'(DIVIDER - 1));
  assign wr_lo = write && (address == ADDR_W'(ADDR_MTIME_LO));
  assign wr_hi = write && (address == ADDR_W'(ADDR_MTIME_HI));
  assign rd_lo = read && !write && (address == ADDR_W'(ADDR_MTIME_LO));

  // A bus write to either mtime half beats a same-cycle tick and restarts the prescaler.
  always_comb begin
    mtime_d  = mtime_q;
    presc_d  = presc_q + 1'b1;
    enable_d = enable_q;
    if (wr_lo || wr_hi) begin
      presc_d = '0;
      if (wr_lo) mtime_d[31:0]  = data;
      if (wr_hi) mtime_d[63:32] = data;
    end else if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end
    if (write && (address == ADDR_W'(ADDR_ENABLE))) enable_d = data[CHANNELS-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      mtime_q  <= '0;
      enable_q <= '0;
    end else begin
      presc_q  <= presc_d;
      mtime_q  <= mtime_d;
      enable_q <= enable_d;
    end
  end

`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] shadow_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     shadow_q <= '0;
    else if (wr_hi) shadow_q <= data;
    else if (rd_lo) shadow_q <= mtime_q[63:32];
  end

  assign hi_rd = shadow_q;
`else
  assign hi_rd = mtime_q[63:32];
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_cmp
    mtimer_comparator #(.K(k), .ADDR_W(ADDR_W)) u_cmp (
      .clock   (clock),
      .reset   (reset),
      .write   (write),
      .address (address),
      .wdata   (data),
      .mtime   (mtime_q),
      .enable  (enable_q[k]),
      .rdata   (cmp_rdata[k]),
      .irq     (timer_interrupt[k])
    );
  end

  // Each comparator returns zero unless addressed, so OR-ing merges them cleanly.
  always_comb begin
    cmp_or = 32'h0;
    for (int k = 0; k < CHANNELS; k++) cmp_or |= cmp_rdata[k];
  end

  always_comb begin
    rd_data = cmp_or;
    if (address == ADDR_W'(ADDR_MTIME_LO))    rd_data = mtime_q[31:0];
    else if (address == ADDR_W'(ADDR_MTIME_HI)) rd_data = hi_rd;
    else if (address == ADDR_W'(ADDR_STATUS)) rd_data = 32'(timer_interrupt);
    else if (address == ADDR_W'(ADDR_ENABLE)) rd_data = 32'(enable_q);
  end

  assign data = (read && !write) ? rd_data : 32'bz;

endmodule
